alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  ALU-side responder for the controller->ALU op interface. Accepts one op
//  (opcode, data_a, data_b) via valid/ready, executes it, and returns the
//  result y with flags Z/N/C via valid/ready. Logic/arith ops take 1 cycle.
//  MUL uses an iterative shift-add unit. Sits between register-file controller and writeback.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a power of 2, >= 8
//  MUL_EN  1   1: opcode 3'b111 = iterative MUL; 0: 3'b111 returns y=0, err=1
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   1      op request present
//  req_ready    out  1      unit can accept a request
//  alu_op_code  in   3      opcode (alu_pkg::alu_op_e)
//  data_a       in   WIDTH  operand A
//  data_b       in   WIDTH  operand B
//  resp_valid   out  1      result available
//  resp_ready   in   1      consumer accepts result
//  y            out  WIDTH  result
//  Z            out  1      y == 0
//  N            out  1      y[WIDTH-1]
//  C            out  1      ADD: carry-out; SUB: borrow (A<B unsigned); otherwise 0
//  err          out  1      unsupported opcode (MUL with MUL_EN=0)
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0; y=0; Z=1; N=C=err=0; mul counter=0.
//    Reset asserted mid-MUL or mid-RESP aborts the op. No response is produced.
//  - Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR,
//    101 SLL A<<B[log2 WIDTH-1:0], 110 SRL (logical), 111 MUL (low WIDTH bits).
//  - Accept = req_valid & req_ready at a rising edge; operands/opcode latched then.
//  - FSM IDLE: req_ready=1, resp_valid=0. On accept:
//    non-MUL -> compute, register y/flags, -> RESP.
//    MUL -> MUL_BUSY, cnt=0.
//  - MUL_BUSY: req_ready=0. Each edge adds the shifted multiplicand if the current multiplier bit is set.
//    When cnt==WIDTH-1, the last bit is processed, flags are registered, and the FSM goes to RESP.
//  - RESP: resp_valid=1, req_ready=0. y/Z/N/C/err stay stable until resp_ready.
//    On resp_valid & resp_ready the FSM goes to IDLE. There is no bypass: a new request is accepted
//    no earlier than the cycle after the handshake.
//  - Latency (accept edge to resp_valid high): 1 cycle for non-MUL; WIDTH cycles for MUL.
//    Throughput is at most one op per 2 cycles.
//  - Width rules: ADD/SUB are computed at WIDTH+1 bits for C; the result wraps mod 2^WIDTH.
//    Shift amount uses only the low log2(WIDTH) bits of B. MUL drops the upper half of the product.
//  - Z/N are derived from the registered y. Z/N/C/err are updated only when a result is registered.
//  - Inputs are ignored outside IDLE; req_valid held high while busy is not an error.
// STRUCTURE
//  - alu_pkg: typedef enum logic [2:0] alu_op_e {ADD,SUB,AND,OR,XOR,SLL,SRL,MUL};
//    typedef enum {IDLE,MUL_BUSY,RESP} alu_state_e; default WIDTH constant.
//  - Sub-module alu_seq_mul: start/done iterative shift-add multiplier, WIDTH-cycle,
//    async reset. Owns the counter, multiplicand and accumulator.
//  - Top: FSM, operand latch, single-cycle datapath, output/flag registers.
// TESTING
//  1. ADD A=32'hFFFF_FFFF B=1 -> after 1 cycle: resp_valid=1, y=0, Z=1, C=1, N=0.
//  2. SUB A=5 B=7 -> y=32'hFFFF_FFFE, N=1, C=1, Z=0. SUB A=9 B=9 -> y=0, Z=1, C=0.
//  3. MUL A=32'h0001_0003 B=32'h0000_0005 -> resp_valid exactly 32 cycles after accept,
//     y=32'h0005_000F. req_ready=0 throughout.
//  4. SLL A=1 B=32'h0000_0025 (shamt 5) -> y=32'h20. SRL A=32'h8000_0000 B=31 -> y=1.
//  5. resp_ready held 0 for 10 cycles with req_valid=1 and new operands -> y and flags stable,
//     no second accept. Release -> IDLE, next op accepted the following cycle.
//  6. Assert rst at cycle 10 of a MUL -> resp_valid=0, req_ready=1, y=0, Z=1 immediately.
//     A following ADD 2+3 gives y=5. With MUL_EN=0, opcode 111 -> y=0, err=1, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU execution unit.
package alu_pkg;

    localparam int unsigned AluWidth = 32;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpSll = 3'b101,
        OpSrl = 3'b110,
        OpMul = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMulBusy,
        StResp
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// product_o is valid while done_o is high (the final bit is folded in combinationally).
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] partial;

    assign partial   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done_o    = busy_q && (cnt_q == CntLast);
    assign product_o = partial;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU responder: valid/ready op in, registered result and flags out.
// Single-cycle ops register on the accept edge; MUL runs through alu_seq_mul.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = AluWidth,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       alu_op_code,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] y,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             err
);

    localparam int unsigned ShW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic             err_q, err_d;

    alu_op_e          op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op    = alu_op_e'(alu_op_code);
    assign sum   = {1'b0, data_a} + {1'b0, data_b};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff  = {1'b0, data_a} - {1'b0, data_b};
    assign shamt = data_b[ShW-1:0];

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        unique case (op)
            OpAdd: {alu_c, alu_y} = sum;
            OpSub: {alu_c, alu_y} = diff;
            OpAnd: alu_y = data_a & data_b;
            OpOr:  alu_y = data_a | data_b;
            OpXor: alu_y = data_a ^ data_b;
            OpSll: alu_y = data_a << shamt;
            OpSrl: alu_y = data_a >> shamt;
            OpMul: alu_y = '0;
        endcase
    end

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (data_a),
        .b_i      (data_b),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        c_d        = c_q;
        err_d      = err_q;
        mul_start  = 1'b0;
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (op == OpMul) begin
                        if (MUL_EN) begin
                            mul_start = 1'b1;
                            state_d   = StMulBusy;
                        end else begin
                            y_d     = '0;
                            c_d     = 1'b0;
                            err_d   = 1'b1;
                            state_d = StResp;
                        end
                    end else begin
                        y_d     = alu_y;
                        c_d     = alu_c;
                        err_d   = 1'b0;
                        state_d = StResp;
                    end
                end
            end
            StMulBusy: begin
                if (mul_done) begin
                    y_d     = mul_product;
                    c_d     = 1'b0;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            y_q     <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign y   = y_q;
    assign Z   = (y_q == '0);
    assign N   = y_q[WIDTH-1];
    assign C   = c_q;
    assign err = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results, monitor pops on handshake.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         err;
        bit           is_mul;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   alu_op_code = '0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] y;
    logic         Z, N, C, err;

    logic         nm_req_valid = 1'b0;
    logic         nm_req_ready;
    logic [2:0]   nm_op = '0;
    logic [W-1:0] nm_a = '0;
    logic [W-1:0] nm_b = '0;
    logic         nm_resp_valid;
    logic         nm_resp_ready = 1'b0;
    logic [W-1:0] nm_y;
    logic         nm_z, nm_n, nm_c, nm_err;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_edge = 0;
    int   last_acc = 0;
    int   rr_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .y(y), .Z(Z), .N(N), .C(C), .err(err)
    );

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .req_valid(nm_req_valid), .req_ready(nm_req_ready),
        .alu_op_code(nm_op), .data_a(nm_a), .data_b(nm_b),
        .resp_valid(nm_resp_valid), .resp_ready(nm_resp_ready),
        .y(nm_y), .Z(nm_z), .N(nm_n), .C(nm_c), .err(nm_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int acc);
        exp_t e;
        logic [63:0] wide;
        e.y = '0;
        e.c = 1'b0;
        e.err = 1'b0;
        e.is_mul = (op == 3'b111);
        e.acc = acc;
        case (op)
            3'b000: begin
                wide = 64'(a) + 64'(b);
                e.y = wide[W-1:0];
                e.c = wide[W];
            end
            3'b001: begin
                e.y = a - b;
                e.c = (a < b);
            end
            3'b010: e.y = a & b;
            3'b011: e.y = a | b;
            3'b100: e.y = a ^ b;
            3'b101: e.y = a << (b % W);
            3'b110: e.y = a >> (b % W);
            default: begin
                wide = 64'(a) * 64'(b);
                e.y = wide[W-1:0];
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: resp_ready = ($urandom_range(0, 3) != 0);
            1: resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    // Monitor: checks every presented response against the queue head until it is taken.
    initial begin
        exp_t e;
        bit prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rv = 1'b0;
                continue;
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got y=%h with empty scoreboard", y);
                end else begin
                    e = sb_q[0];
                    if (!prev_rv) begin
                        // Single-cycle ops show resp_valid right after the accept edge.
                        check("latency", 64'(cyc - e.acc), e.is_mul ? 64'(W) : 64'd0);
                    end
                    check("resp", 64'({y, Z, N, C, err}),
                          64'({e.y, (e.y == '0), e.y[W-1], e.c, e.err}));
                    if (resp_ready) begin
                        void'(sb_q.pop_front());
                        hs_edge = cyc + 1;
                    end
                end
            end
            prev_rv = resp_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        int n;
        n = 0;
        req_valid = 1'b1;
        alu_op_code = op;
        data_a = a;
        data_b = b;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready got 0 want 1 after %0d cycles", n);
        end else begin
            last_acc = cyc + 1;
            if (push) sb_q.push_back(model(op, a, b, cyc + 1));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || resp_valid) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation got stuck, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_ready;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({req_ready, resp_valid, y, Z, N, C, err}),
              64'({1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(OpAdd, 32'hFFFF_FFFF, 32'h1, 1'b1);
        issue(OpSub, 32'd5, 32'd7, 1'b1);
        issue(OpSub, 32'd9, 32'd9, 1'b1);
        issue(OpMul, 32'h0001_0003, 32'h0000_0005, 1'b1);
        any_ready = 1'b0;
        repeat (31) begin
            @(negedge clk);
            any_ready |= req_ready;
        end
        check("mul_busy_not_ready", 64'(any_ready), 64'd0);
        issue(OpSll, 32'h1, 32'h25, 1'b1);
        issue(OpSrl, 32'h8000_0000, 32'd31, 1'b1);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: result must hold and no new op may be taken.
        rr_mode = 1;
        resp_ready = 1'b0;
        issue(OpSub, 32'd3, 32'd10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            alu_op_code = 3'($urandom_range(0, 6));
            data_a = W'($urandom);
            data_b = W'($urandom);
            @(negedge clk);
            check("stall_no_accept", 64'({req_ready, resp_valid}), 64'({1'b0, 1'b1}));
            @(posedge clk);
            #1;
        end
        rr_mode = 2;
        resp_ready = 1'b1;
        issue(OpXor, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b1);
        check("accept_after_hs", 64'(last_acc - hs_edge), 64'd1);
        drain();

        // Reset in the middle of a MUL aborts it with no response.
        rr_mode = 0;
        issue(OpMul, W'($urandom), W'($urandom), 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_abort", 64'({resp_valid, req_ready, y, Z}),
              64'({1'b0, 1'b1, 32'h0, 1'b1}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(OpAdd, 32'd2, 32'd3, 1'b1);
        drain();

        // MUL_EN=0 instance: opcode 111 is unsupported.
        nm_req_valid = 1'b1;
        nm_op = 3'b111;
        nm_a = W'($urandom);
        nm_b = W'($urandom);
        @(negedge clk);
        check("nomul_ready", 64'(nm_req_ready), 64'd1);
        @(posedge clk);
        #1;
        nm_req_valid = 1'b0;
        @(negedge clk);
        check("nomul_resp", 64'({nm_resp_valid, nm_y, nm_z, nm_err}),
              64'({1'b1, 32'h0, 1'b1, 1'b1}));
        nm_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("nomul_idle", 64'(nm_resp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
